// File: rtl/pixel_writer.sv
// Pixel handshake responder: takes one pixel per data_ready rising edge, clips it to
// the frame, issues a single Avalon-MM write to the frame buffer and pulses data_sent.
module pixel_writer #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int COORD_W   = 10,
  parameter int COLOR_W   = 24,
  parameter int BPP_BYTES = 4,
  parameter int ADDR_W    = 32
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               data_ready,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [COLOR_W-1:0] pixel_color,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               shape_done,
  output logic [ADDR_W-1:0]  avm_address,
  output logic               avm_write,
  output logic [31:0]        avm_writedata,
  input  logic               avm_waitrequest,
  output logic               data_sent,
  output logic               busy,
  output logic [15:0]        pix_count,
  output logic [15:0]        clip_count,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, ADDR, WRITE, DONE} state_e;

  localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(WIDTH);
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(HEIGHT);

  state_e             state_q, state_d;
  logic               ready_q;
  logic               new_pix;
  logic               off_frame;
  logic               pix_inc, clip_inc;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COLOR_W-1:0] color_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q;
  logic [15:0]        pix_q, clip_q;
  logic               ovr_q;

  assign new_pix   = data_ready & ~ready_q;
  assign off_frame = ({1'b0, pixel_x} >= W_LIM) || ({1'b0, pixel_y} >= H_LIM);

  // Truncating to ADDR_W is modular, so evaluating the whole expression at
  // ADDR_W bits yields the same address as a wider computation.
  assign addr_d = base_addr
                + (ADDR_W'(y_q) * ADDR_W'(WIDTH) + ADDR_W'(x_q)) * ADDR_W'(BPP_BYTES);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= data_ready;
    end
  end

  always_comb begin
    state_d  = state_q;
    pix_inc  = 1'b0;
    clip_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (new_pix) begin
          if (off_frame) begin
            state_d  = DONE;
            clip_inc = 1'b1;
          end else begin
            state_d  = ADDR;
          end
        end
      end
      ADDR:  state_d = WRITE;
      WRITE: begin
        if (!avm_waitrequest) begin
          state_d = DONE;
          pix_inc = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (state_q == IDLE && new_pix) begin
        x_q     <= pixel_x;
        y_q     <= pixel_y;
        color_q <= pixel_color;
      end
      if (state_q == ADDR) begin
        addr_q  <= addr_d;
        wdata_q <= 32'(color_q);
      end
    end
  end

  // shape_done takes priority over a coinciding increment or overrun set.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pix_q  <= '0;
      clip_q <= '0;
      ovr_q  <= 1'b0;
    end else if (shape_done) begin
      pix_q  <= '0;
      clip_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (pix_inc && pix_q != 16'hFFFF)   pix_q  <= pix_q + 16'd1;
      if (clip_inc && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
      if (new_pix && state_q != IDLE)     ovr_q  <= 1'b1;
    end
  end

  // Strobes decode the state register so reset drops them asynchronously.
  assign avm_write     = (state_q == WRITE);
  assign data_sent     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign pix_count     = pix_q;
  assign clip_count    = clip_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Randomized bench for pixel_writer against a transaction-level model of the
// frame-buffer address, handshake latency and counters.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        nreset;
  logic        data_ready;
  logic [9:0]  pixel_x, pixel_y;
  logic [23:0] pixel_color;
  logic [31:0] base_addr;
  logic        shape_done;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        data_sent, busy;
  logic [15:0] pix_count, clip_count;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  int m_pix  = 0;
  int m_clip = 0;
  bit m_ovr  = 1'b0;

  pixel_writer dut (
    .clk(clk), .nreset(nreset), .data_ready(data_ready),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
    .base_addr(base_addr), .shape_done(shape_done),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .data_sent(data_sent), .busy(busy),
    .pix_count(pix_count), .clip_count(clip_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_state();
    chk("pix_count",  64'(pix_count),  64'(m_pix));
    chk("clip_count", 64'(clip_count), 64'(m_clip));
    chk("overrun",    64'(overrun),    64'(m_ovr));
    chk("busy_idle",  64'(busy),       64'd0);
  endtask

  // One pixel transaction. Observation index k means cycle N+k, N = edge cycle.
  task automatic send_pixel(input int x, input int y, input logic [23:0] c,
                            input logic [31:0] base, input int waits, input int hold,
                            input bit glitch, input bit sd_end);
    bit          clip;
    int          wc, ds, dsk, exp_k;
    longint      lin;
    logic [31:0] exp_addr;
    clip     = (x >= 640) || (y >= 480);
    lin      = longint'(base) + (longint'(y) * 640 + longint'(x)) * 4;
    exp_addr = lin[31:0];
    exp_k    = clip ? 1 : 3 + waits;
    wc = 0; ds = 0; dsk = -1;
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y); pixel_color = c; base_addr = base;
    avm_waitrequest = 1'b0; data_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      shape_done = 1'b0;
      if (avm_write) begin
        wc++;
        chk("wr_addr", 64'(avm_address), 64'(exp_addr));
        chk("wr_data", 64'(avm_writedata), {40'd0, c});
      end
      if (data_sent) begin
        ds++;
        if (dsk < 0) dsk = k;
        chk("ds_vs_write", 64'(avm_write), 64'd0);
      end
      avm_waitrequest = avm_write && (wc <= waits);
      if (sd_end && avm_write && wc == waits + 1) shape_done = 1'b1;
      if (k == hold) data_ready = 1'b0;
      if (glitch && k == 2) data_ready = 1'b1;
      if (glitch && k == 3) data_ready = 1'b0;
    end
    avm_waitrequest = 1'b0;
    if (glitch) m_ovr = 1'b1;
    if (clip) m_clip = (m_clip < 65535) ? m_clip + 1 : 65535;
    else      m_pix  = (m_pix  < 65535) ? m_pix  + 1 : 65535;
    if (sd_end && !clip) begin m_pix = 0; m_clip = 0; m_ovr = 1'b0; end
    chk("ds_cycle",    64'(dsk), 64'(exp_k));
    chk("ds_pulses",   64'(ds),  64'd1);
    chk("write_cycles", 64'(wc), clip ? 64'd0 : 64'(waits + 1));
    chk_state();
  endtask

  task automatic pulse_shape_done();
    @(negedge clk); shape_done = 1'b1;
    @(negedge clk); shape_done = 1'b0;
    m_pix = 0; m_clip = 0; m_ovr = 1'b0;
    chk_state();
  endtask

  initial begin
    int x, y, w, h;
    bit g, s;
    nreset = 1'b0; data_ready = 1'b0; pixel_x = '0; pixel_y = '0; pixel_color = '0;
    base_addr = '0; shape_done = 1'b0; avm_waitrequest = 1'b0;
    #12;
    chk("rst_write", 64'(avm_write), 64'd0);
    chk("rst_addr",  64'(avm_address), 64'd0);
    chk("rst_data",  64'(avm_writedata), 64'd0);
    chk("rst_sent",  64'(data_sent), 64'd0);
    chk_state();
    @(negedge clk); nreset = 1'b1;

    // directed: basic, wait states, clips, level hold, overrun, corner
    send_pixel(3, 2, 24'hFF0000, 32'h1000_0000, 0, 1, 1'b0, 1'b0);
    send_pixel(3, 2, 24'hFF0000, 32'h1000_0000, 4, 1, 1'b0, 1'b0);
    send_pixel(640, 0, 24'h00FF00, 32'h1000_0000, 0, 1, 1'b0, 1'b0);
    send_pixel(0, 480, 24'h0000FF, 32'h1000_0000, 0, 1, 1'b0, 1'b0);
    send_pixel(10, 10, 24'h123456, 32'h2000_0000, 0, 10, 1'b0, 1'b0);
    send_pixel(20, 30, 24'hABCDEF, 32'h2000_0000, 3, 1, 1'b1, 1'b0);
    pulse_shape_done();
    send_pixel(639, 479, 24'hFFFFFF, 32'h0, 0, 1, 1'b0, 1'b0);
    send_pixel(1023, 1023, 24'h777777, 32'h0, 0, 3, 1'b0, 1'b0);
    send_pixel(5, 5, 24'h010203, 32'hFFFF_FF00, 2, 1, 1'b0, 1'b1);

    // randomized pixels
    for (int i = 0; i < 150; i++) begin
      x = int'($urandom_range(0, 700));
      y = int'($urandom_range(0, 520));
      w = int'($urandom_range(0, 3));
      h = int'($urandom_range(1, 6));
      g = ($urandom_range(0, 5) == 0) && (x < 640) && (y < 480);
      s = ($urandom_range(0, 9) == 0);
      if (g) h = 1;
      send_pixel(x, y, 24'($urandom), $urandom & 32'hFFFF_FFFC, w, h, g, s);
      if ($urandom_range(0, 19) == 0) pulse_shape_done();
    end

    // reset while a write is stalled
    @(negedge clk);
    pixel_x = 10'd7; pixel_y = 10'd8; pixel_color = 24'h55AA55; base_addr = 32'h0;
    avm_waitrequest = 1'b1; data_ready = 1'b1;
    @(negedge clk); data_ready = 1'b0;
    @(negedge clk);
    chk("stall_write", 64'(avm_write), 64'd1);
    #2 nreset = 1'b0;
    #1;
    chk("async_wr_drop", 64'(avm_write), 64'd0);
    chk("async_busy",    64'(busy),      64'd0);
    chk("async_sent",    64'(data_sent), 64'd0);
    @(negedge clk); avm_waitrequest = 1'b0;
    @(negedge clk); nreset = 1'b1;
    m_pix = 0; m_clip = 0; m_ovr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_sent", 64'(data_sent), 64'd0);
    end
    chk_state();
    send_pixel(100, 200, 24'hC0FFEE, 32'h0800_0000, 1, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
